// File: rtl/reset_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reset_seq : staged reset sequencer, releases N active-low resets in order |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module reset_seq #(
    parameter int N   = 4,
    parameter int DLY = 16,
    parameter int PW  = 8,
    parameter int DW  = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         swr_i,
    input  logic [N-1:0] ready_i,
    output logic [N-1:0] rst_n_o,
    output logic         done_o,
    output logic         busy_o
);

    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [DW-1:0] DLY_LOAD = DW'(DLY - 1);
    localparam logic [DW-1:0] PW_LOAD  = DW'(PW - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        WAIT  = 3'd1,
        DELAY = 3'd2,
        RUN   = 3'd3,
        SWRST = 3'd4
    } state_t;

    state_t          state;
    logic [DW-1:0]   cnt;
    logic [KW-1:0]   k;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= HOLD;
            cnt     <= DLY_LOAD;
            k       <= '0;
            rst_n_o <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b1;
        end else if (swr_i && (state != SWRST)) begin
            state   <= SWRST;
            cnt     <= PW_LOAD;
            rst_n_o <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt == '0) begin
                        rst_n_o <= N'(1);
                        k       <= '0;
                        state   <= WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (ready_i[k]) begin
                        if (k == K_LAST) begin
                            state  <= RUN;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                        end else begin
                            state <= DELAY;
                            cnt   <= DLY_LOAD;
                        end
                    end
                end
                DELAY: begin
                    // Released bits are always a contiguous low run, so a
                    // shift-in of one releases exactly stage k+1.
                    if (cnt == '0) begin
                        rst_n_o <= (rst_n_o << 1) | N'(1);
                        k       <= k + KW'(1);
                        state   <= WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RUN: begin
                end
                SWRST: begin
                    if ((cnt == '0) && !swr_i) begin
                        state <= HOLD;
                        cnt   <= DLY_LOAD;
                        k     <= '0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/reset_seq.md
# reset_seq

Staged reset sequencer that sits directly downstream of the reset synchronizer. It takes the already-synchronized system reset and releases `N` block-level active-low resets one at a time, in index order. Before each next stage is released, the sequencer waits for the previous stage's readiness flag (PLL lock, memory init, etc.) and then for a fixed guard delay. A software reset request re-runs the whole sequence without involving the external reset pin.

## Interface
- `N`, default 4: number of reset stages; minimum 1.
- `DLY`, default 16: guard delay in cycles before each stage release; minimum 1.
- `PW`, default 8: minimum software-reset assertion width in cycles; minimum 1.
- `DW`, default 8: internal counter width; must hold `max(DLY,PW)-1`.

Ports:
- `clk_i` input 1: the single clock.
- `rst_i` input 1: synchronous, active-high reset from the synchronizer.
- `swr_i` input 1: software reset request; level-sensitive and synchronous to `clk_i`.
- `ready_i` input N: per-stage ready flags; bit k is sampled only while waiting on stage k.
- `rst_n_o` output N: staged active-low resets; bit 0 is released first.
- `done_o` output 1: high when every stage is released and `ready_i[N-1]` has been seen.
- `busy_o` output 1: exactly `~done_o`.

## Operation
- All outputs are registered.
- **Reset** (`rst_i` high at an edge):
  - state=HOLD, `cnt=DLY-1`, stage index `k=0`.
  - `rst_n_o` all 0, `done_o=0`, `busy_o=1`.
  - `rst_i` overrides everything, including `swr_i`.
- **States:** HOLD, WAIT, DELAY, RUN, SWRST.
- **HOLD:**
  - At each edge: if `cnt==0`, set `rst_n_o[0]=1`, `k=0`, go to WAIT; else `cnt--`.
- **WAIT** (stage k released):
  - If `ready_i[k]==1`:
    - when `k==N-1`, go to RUN with `done_o=1`;
    - otherwise go to DELAY with `cnt=DLY-1`.
  - If `ready_i[k]==0`, stay in WAIT indefinitely. There is no timeout.
- **DELAY:**
  - If `cnt==0`, set `rst_n_o[k+1]=1`, `k++`, go to WAIT; else `cnt--`.
  - `ready_i` is ignored in DELAY.
- **RUN:**
  - Outputs are static; `ready_i` is ignored, including drops.
- **SWRST entry:**
  - From HOLD, WAIT, DELAY or RUN, `swr_i` sampled high goes to SWRST.
  - On entry: `rst_n_o` all 0, `done_o=0`, `cnt=PW-1`.
- **SWRST:**
  - If `cnt==0` and `swr_i==0`, go to HOLD with `cnt=DLY-1`, `k=0`.
  - Otherwise `cnt = (cnt==0) ? 0 : cnt-1`.
  - `swr_i` held high extends SWRST for as long as it stays high.
- **Priority at one edge:** `rst_i` > `swr_i` > `ready_i` / counter expiry.
- **Release order:** `rst_n_o` bits only ever rise in index order and only one per edge. All bits fall together.
- **Counters:** `cnt` is unsigned and never wraps; decrements saturate at 0.

## Timing
- Edge 0 is the last edge with `rst_i` high. With `ready_i` held all-ones:
  - `rst_n_o[k]` rises at edge `DLY + k*(DLY+1)`;
  - `done_o` rises at edge `N*(DLY+1)`.
- `ready_i[k]` first sampled high at edge e while in WAIT:
  - `rst_n_o[k+1]` rises at edge `e+DLY`;
  - for `k==N-1`, `done_o` rises at edge e.
- `swr_i` sampled high at edge e, for 1 cycle:
  - outputs low after e;
  - `rst_n_o[0]` rises at edge `e+PW+DLY`.
- `swr_i` held high for edges e..f with `f-e ≥ PW-1`: `rst_n_o[0]` rises at `f+1+DLY`.
- `rst_i` asserted mid-sequence: all outputs return to their reset values after that edge. Re-release timing restarts from the last `rst_i`-high edge.
- `N=1`: HOLD → WAIT → RUN; DELAY is never entered.

## Test plan
- Power-up, N=4, DLY=16, `ready_i`=4'b1111, `rst_i` low after edge 0 → `rst_n_o` rises at bits 0..3 at edges 16, 33, 50, 67; `done_o` rises at edge 68; `busy_o` falls at edge 68.
- `ready_i[1]` held 0 until edge 100 → `rst_n_o` stays 4'b0011 through edge 115. `rst_n_o[2]` rises at edge 116. `done_o` stays 0 meanwhile.
- In RUN, 1-cycle `swr_i` at edge 200 with PW=8 → `rst_n_o`=0 and `done_o`=0 after edge 200. `rst_n_o[0]` rises at edge 224; the full sequence repeats.
- `swr_i` held high for 30 edges from edge 200 → outputs stay 0 through edge 229. `rst_n_o[0]` rises at edge 246.
- `rst_i` pulsed for 1 cycle in DELAY of stage 2, together with `swr_i` high in the same cycle → all outputs 0 next edge. State is HOLD, not SWRST. `rst_n_o[0]` rises DLY edges later.
- In RUN, `ready_i` toggled randomly for 50 cycles → `rst_n_o`=4'b1111 and `done_o`=1 throughout.
